// File: rtl/program_loader.sv
// program_loader: streams a program over a valid/ready byte port into CPU ROM.
// Byte k is written to ROM address k with its own edit/unit/code/send cycle.
// The FSM keeps unit/code stable for a full cycle before and after each send
// pulse, and it keeps edit high for the whole load.
module program_loader #(
  parameter int ROM_DEPTH = 256,
  parameter int SEND_W    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [8:0] prog_len_i,
  input  logic       abort_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       edit_o,
  output logic [7:0] unit_o,
  output logic [7:0] code_o,
  output logic       send_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  // The strobe counter is at least one bit wide, even when SEND_W == 1.
  localparam int CNT_W = (SEND_W > 1) ? $clog2(SEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEND_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WAIT   = 3'd2,
    S_SETUP  = 3'd3,
    S_STROBE = 3'd4,
    S_HOLD   = 3'd5,
    S_CLOSE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       len_q, len_d;
  logic [8:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abrt_q, abrt_d;
  logic [7:0]       unit_q, unit_d;
  logic [7:0]       code_q, code_d;
  logic             edit_q, edit_d;
  logic             send_q, send_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             len_ok_s;

  // A requested length is legal when it is 1..ROM_DEPTH.
  always_comb begin
    len_ok_s = (prog_len_i != 9'd0) && ({23'd0, prog_len_i} <= 32'(ROM_DEPTH));
  end

  // Next-state logic and datapath updates. An abort in any active state except
  // CLOSE diverts to CLOSE and marks the load as failed.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    abrt_d  = abrt_q;
    unit_d  = unit_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_ok_s) begin
            state_d = S_ARM;
            len_d   = prog_len_i;
            addr_d  = 9'd0;
            abrt_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (abort_i) begin
          state_d = S_CLOSE;
          abrt_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_CLOSE;
          abrt_d  = 1'b1;
        end else if (in_valid_i && in_ready_q) begin
          code_d  = in_data_i;
          unit_d  = addr_q[7:0];
          state_d = S_SETUP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SETUP: begin
        if (abort_i) begin
          state_d = S_CLOSE;
          abrt_d  = 1'b1;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (abort_i) begin
          state_d = S_CLOSE;
          abrt_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_HOLD: begin
        if (abort_i) begin
          state_d = S_CLOSE;
          abrt_d  = 1'b1;
        end else if (addr_q == (len_q - 9'd1)) begin
          state_d = S_CLOSE;
        end else begin
          addr_d  = addr_q + 9'd1;
          state_d = S_WAIT;
        end
      end
      S_CLOSE: begin
        state_d = S_IDLE;
        done_d  = ~abrt_q;
        err_d   = abrt_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs follow the state being entered, so every output is a flop.
  always_comb begin
    edit_d     = (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_SETUP) ||
                 (state_d == S_STROBE) || (state_d == S_HOLD);
    send_d     = (state_d == S_STROBE);
    in_ready_d = (state_d == S_WAIT);
    busy_d     = (state_d != S_IDLE);
  end

  // State, datapath and output registers. Reset drops edit/send immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= 9'd0;
      addr_q     <= 9'd0;
      cnt_q      <= {CNT_W{1'b0}};
      abrt_q     <= 1'b0;
      unit_q     <= 8'd0;
      code_q     <= 8'd0;
      edit_q     <= 1'b0;
      send_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      abrt_q     <= abrt_d;
      unit_q     <= unit_d;
      code_q     <= code_d;
      edit_q     <= edit_d;
      send_q     <= send_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready_o = in_ready_q;
  assign edit_o     = edit_q;
  assign unit_o     = unit_q;
  assign code_o     = code_q;
  assign send_o     = send_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. The reference model is the list of ROM writes
// (address k gets byte k) that a load should produce. A monitor records each
// send pulse and watches the edit and stable-data rules.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [8:0] prog_len_i;
  logic       abort_i;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o, edit_o, send_o, busy_o, done_o, err_o;
  logic [7:0] unit_o, code_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  program_loader #(.ROM_DEPTH(256), .SEND_W(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .prog_len_i(prog_len_i),
    .abort_i(abort_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .edit_o(edit_o), .unit_o(unit_o), .code_o(code_o),
    .send_o(send_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure byte-to-byte spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records writes and watches the protocol rules.
  logic [15:0] wr_q[$];
  int done_cnt = 0, err_cnt = 0, stab_viol = 0, edit_viol = 0, edit_falls = 0, send_cycles = 0;
  logic prev_send = 1'b0, prev_edit = 1'b0;
  logic [7:0] prev_unit = 8'd0, prev_code = 8'd0;

  always @(negedge clk) begin
    if (send_o === 1'b1 && prev_send !== 1'b1) wr_q.push_back({unit_o, code_o});
    if ((send_o === 1'b1 || prev_send === 1'b1) && ({unit_o, code_o} !== {prev_unit, prev_code}))
      stab_viol <= stab_viol + 1;
    if ((send_o === 1'b1 || in_ready_o === 1'b1) && edit_o !== 1'b1) edit_viol <= edit_viol + 1;
    if (prev_edit === 1'b1 && edit_o === 1'b0) edit_falls <= edit_falls + 1;
    if (send_o === 1'b1) send_cycles <= send_cycles + 1;
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (err_o === 1'b1) err_cnt <= err_cnt + 1;
    prev_send <= send_o;
    prev_edit <= edit_o;
    prev_unit <= unit_o;
    prev_code <= code_o;
  end

  // Number of entries that differ between the recorded writes and e.
  function automatic int count_diffs(input logic [15:0] e[$]);
    int n;
    int m;
    n = (e.size() > wr_q.size()) ? (e.size() - wr_q.size()) : (wr_q.size() - e.size());
    m = (e.size() < wr_q.size()) ? e.size() : wr_q.size();
    for (int i = 0; i < m; i++) if (wr_q[i] !== e[i]) n++;
    return n;
  endfunction

  // Pulse start for one cycle, then scramble prog_len (must be ignored).
  task automatic start_load(input int len);
    start_i = 1'b1;
    prog_len_i = len[8:0];
    @(negedge clk);
    start_i = 1'b0;
    prog_len_i = 9'($urandom);
  endtask

  // Offer one byte after gap idle cycles; acc returns the accept cycle.
  task automatic feed_byte(input logic [7:0] b, input int gap, output int acc);
    int t;
    in_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i = b;
    t = 0;
    while (in_ready_o !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests_run++;
      tests_failed++;
      $display("FAIL feed_timeout: in_ready=%b after %0d cycles, required 1", in_ready_o, t);
      acc = -1;
    end else begin
      @(negedge clk);
      acc = cyc;
    end
    in_valid_i = 1'b0;
    in_data_i = 8'($urandom);
  endtask

  // Wait until the loader returns to IDLE, then let the monitor settle.
  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_o !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests_run++;
      tests_failed++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; prog_len_i = 9'd0; abort_i = 1'b0;
    in_data_i = 8'd0; in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready_o, edit_o, unit_o, code_o, send_o, busy_o, done_o, err_o} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required 0",
               {in_ready_o, edit_o, unit_o, code_o, send_o, busy_o, done_o, err_o});
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] exp[$];
    logic [7:0] bytes [3];
    int acc[3];
    int d0, f0, s0;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    wr_q.delete();
    d0 = done_cnt; f0 = edit_falls; s0 = send_cycles;
    start_load(3);
    tests_run++;
    if (edit_o !== 1'b1 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_arm: edit=%b busy=%b, required 1 1", edit_o, busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      feed_byte(bytes[i], 0, acc[i]);
      exp.push_back({i[7:0], bytes[i]});
    end
    wait_idle();
    tests_run++;
    if (count_diffs(exp) != 0) begin
      tests_failed++;
      $display("FAIL basic_writes: %0d writes, %0d differ, required 3 matching", wr_q.size(), count_diffs(exp));
    end
    tests_run++;
    if ((acc[1] - acc[0]) != 4 || (acc[2] - acc[1]) != 4) begin
      tests_failed++;
      $display("FAIL basic_spacing: got %0d,%0d cycles, required 4,4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    tests_run++;
    if ((done_cnt - d0) != 1 || (edit_falls - f0) != 1 || (send_cycles - s0) != 3) begin
      tests_failed++;
      $display("FAIL basic_done_edit: done=%0d edit_falls=%0d send_cycles=%0d, required 1 1 3",
               done_cnt - d0, edit_falls - f0, send_cycles - s0);
    end
  endtask

  task automatic test_illegal_len();
    int lens[2];
    int e0, d0;
    lens[0] = 0; lens[1] = 257;
    wr_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 2; i++) begin
      e0 = err_cnt;
      start_load(lens[i]);
      tests_run++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || edit_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_len_%0d: err=%b busy=%b edit=%b, required 1 0 0", lens[i], err_o, busy_o, edit_o);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if ((err_cnt - e0) != 1 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_pulse_%0d: err pulses=%0d busy=%b, required 1 0", lens[i], err_cnt - e0, busy_o);
      end
    end
    tests_run++;
    if (wr_q.size() != 0 || done_cnt != d0) begin
      tests_failed++;
      $display("FAIL illegal_no_write: writes=%0d done=%0d, required 0 0", wr_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_delayed_valid();
    logic [15:0] exp[$];
    logic [7:0] b;
    int acc;
    int d0, f0;
    wr_q.delete();
    d0 = done_cnt; f0 = edit_falls;
    start_load(2);
    for (int i = 0; i < 2; i++) begin
      repeat (5) @(negedge clk);
      tests_run++;
      if (in_ready_o !== 1'b1 || edit_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL delayed_wait_%0d: in_ready=%b edit=%b, required 1 1", i, in_ready_o, edit_o);
      end
      b = 8'($urandom);
      feed_byte(b, 0, acc);
      exp.push_back({i[7:0], b});
    end
    wait_idle();
    tests_run++;
    if (count_diffs(exp) != 0 || (done_cnt - d0) != 1 || (edit_falls - f0) != 1) begin
      tests_failed++;
      $display("FAIL delayed_writes: writes=%0d diffs=%0d done=%0d edit_falls=%0d, required 2 0 1 1",
               wr_q.size(), count_diffs(exp), done_cnt - d0, edit_falls - f0);
    end
  endtask

  task automatic test_abort_strobe();
    logic [15:0] exp[$];
    logic [7:0] b0, b1;
    int acc;
    int d0, e0;
    wr_q.delete();
    d0 = done_cnt; e0 = err_cnt;
    b0 = 8'($urandom); b1 = 8'($urandom);
    start_load(4);
    feed_byte(b0, 0, acc);
    feed_byte(b1, 0, acc);
    exp.push_back({8'd0, b0});
    exp.push_back({8'd1, b1});
    @(negedge clk);
    tests_run++;
    if (send_o !== 1'b1 || unit_o !== 8'd1) begin
      tests_failed++;
      $display("FAIL abort_in_strobe: send=%b unit=%0d, required 1 1", send_o, unit_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    tests_run++;
    if (send_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_send_cut: send=%b, required 0", send_o);
    end
    @(negedge clk);
    tests_run++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || edit_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_err: err=%b done=%b edit=%b, required 1 0 0", err_o, done_o, edit_o);
    end
    wait_idle();
    tests_run++;
    if (count_diffs(exp) != 0 || done_cnt != d0 || (err_cnt - e0) != 1) begin
      tests_failed++;
      $display("FAIL abort_totals: writes=%0d diffs=%0d done=%0d err=%0d, required 2 0 0 1",
               wr_q.size(), count_diffs(exp), done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp[$];
    logic [7:0] b;
    int acc;
    int t;
    start_load(8);
    for (int i = 0; i < 3; i++) feed_byte(8'($urandom), 0, acc);
    t = 0;
    while (in_ready_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    tests_run++;
    if (in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_wait: in_ready=%b, required 1", in_ready_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    tests_run++;
    if ({in_ready_o, edit_o, unit_o, code_o, send_o, busy_o, done_o, err_o} !== 22'd0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got %h, required 0",
               {in_ready_o, edit_o, unit_o, code_o, send_o, busy_o, done_o, err_o});
    end
    repeat (2) @(negedge clk);
    wr_q.delete();
    start_load(2);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      feed_byte(b, 1, acc);
      exp.push_back({i[7:0], b});
    end
    wait_idle();
    tests_run++;
    if (count_diffs(exp) != 0) begin
      tests_failed++;
      $display("FAIL rstmid_reload: writes=%0d diffs=%0d, required 2 0", wr_q.size(), count_diffs(exp));
    end
  endtask

  task automatic test_full_256();
    logic [15:0] exp[$];
    int acc;
    int d0, zeros;
    wr_q.delete();
    d0 = done_cnt;
    start_load(256);
    for (int i = 0; i < 256; i++) begin
      feed_byte(i[7:0], 0, acc);
      exp.push_back({i[7:0], i[7:0]});
    end
    wait_idle();
    zeros = 0;
    foreach (wr_q[i]) if (wr_q[i][15:8] == 8'd0) zeros++;
    tests_run++;
    if (count_diffs(exp) != 0 || (done_cnt - d0) != 1) begin
      tests_failed++;
      $display("FAIL full_writes: writes=%0d diffs=%0d done=%0d, required 256 0 1",
               wr_q.size(), count_diffs(exp), done_cnt - d0);
    end
    tests_run++;
    if (wr_q.size() == 0 || wr_q[wr_q.size() - 1] !== 16'hFFFF || zeros != 1) begin
      tests_failed++;
      $display("FAIL full_last: last=%h unit0_writes=%0d, required ffff 1",
               (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : 16'hxxxx, zeros);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp[$];
    logic [7:0] b;
    int len, acc, d0;
    for (int n = 0; n < 6; n++) begin
      exp.delete();
      wr_q.delete();
      d0 = done_cnt;
      len = $urandom_range(1, 24);
      start_load(len);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        start_i = 1'($urandom_range(0, 1));
        feed_byte(b, $urandom_range(0, 3), acc);
        start_i = 1'b0;
        exp.push_back({i[7:0], b});
      end
      wait_idle();
      tests_run++;
      if (count_diffs(exp) != 0 || (done_cnt - d0) != 1) begin
        tests_failed++;
        $display("FAIL random_load_%0d: len=%0d writes=%0d diffs=%0d done=%0d, required %0d 0 1",
                 n, len, wr_q.size(), count_diffs(exp), done_cnt - d0, len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_len();
    test_delayed_valid();
    test_abort_strobe();
    test_reset_mid();
    test_full_256();
    test_random();
    tests_run++;
    if (stab_viol != 0 || edit_viol != 0) begin
      tests_failed++;
      $display("FAIL protocol_rules: stable_violations=%0d edit_violations=%0d, required 0 0", stab_viol, edit_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
